// File: rtl/divider.sv
// Signed integer divider with valid/ack handshakes on every channel.
//
// Accepts a dividend on in1, then a divisor on in2, runs an unsigned restoring
// division of the operand magnitudes (one quotient bit per cycle, MSB first),
// corrects the sign, and presents the quotient on out1 until acknowledged.
// The quotient truncates toward zero. Divide by zero yields 0. The
// most-negative / -1 case wraps to the most-negative value.
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   in1       dividend (two's complement)
//   in1_stb   dividend valid, held by the sender until acknowledged
//   in1_ack   dividend accepted
//   in2       divisor (two's complement)
//   in2_stb   divisor valid, held by the sender until acknowledged
//   in2_ack   divisor accepted
//   out1      quotient (two's complement)
//   out1_stb  quotient valid
//   out1_ack  receiver accepted the quotient
module divider #(
  parameter int unsigned bits = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] in1,
  input  logic            in1_stb,
  output logic            in1_ack,
  input  logic [bits-1:0] in2,
  input  logic            in2_stb,
  output logic            in2_ack,
  output logic [bits-1:0] out1,
  output logic            out1_stb,
  input  logic            out1_ack
);

  localparam int unsigned CntW = $clog2(bits + 1);

  typedef enum logic [2:0] {
    StGetA,
    StGetB,
    StDivide,
    StFix,
    StPut
  } state_e;

  state_e            state_q, state_d;
  logic              in1_ack_q, in1_ack_d;
  logic              in2_ack_q, in2_ack_d;
  logic              out1_stb_q, out1_stb_d;
  logic [bits-1:0]   out1_q, out1_d;
  // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
  logic [bits-1:0]   quo_q, quo_d;
  logic [bits-1:0]   den_q, den_d;
  logic [bits-1:0]   rem_q, rem_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              a_neg_q, a_neg_d;
  logic              neg_q, neg_d;

  logic [bits:0]     rem_shift;
  logic              rem_ge;

  // Unsigned magnitude; the most-negative value maps to 2^(bits-1), which fits.
  function automatic logic [bits-1:0] mag(input logic [bits-1:0] v);
    return v[bits-1] ? -v : v;
  endfunction

  assign rem_shift = {rem_q, quo_q[bits-1]};
  assign rem_ge    = rem_shift >= {1'b0, den_q};

  always_comb begin
    state_d    = state_q;
    in1_ack_d  = in1_ack_q;
    in2_ack_d  = in2_ack_q;
    out1_stb_d = out1_stb_q;
    out1_d     = out1_q;
    quo_d      = quo_q;
    den_d      = den_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    a_neg_d    = a_neg_q;
    neg_d      = neg_q;

    unique case (state_q)
      StGetA: begin
        in1_ack_d = 1'b1;
        if (in1_stb && in1_ack_q) begin
          in1_ack_d = 1'b0;
          quo_d     = mag(in1);
          a_neg_d   = in1[bits-1];
          state_d   = StGetB;
        end
      end
      StGetB: begin
        in2_ack_d = 1'b1;
        if (in2_stb && in2_ack_q) begin
          in2_ack_d = 1'b0;
          den_d     = mag(in2);
          neg_d     = a_neg_q ^ in2[bits-1];
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = StDivide;
        end
      end
      StDivide: begin
        // Remainder stays below the divisor, so its low bits carry the whole difference.
        rem_d = rem_ge ? (rem_shift[bits-1:0] - den_q) : rem_shift[bits-1:0];
        quo_d = {quo_q[bits-2:0], rem_ge};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(bits - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (den_q == '0) begin
          out1_d = '0;
        end else begin
          out1_d = neg_q ? -quo_q : quo_q;
        end
        out1_stb_d = 1'b1;
        state_d    = StPut;
      end
      StPut: begin
        if (out1_ack && out1_stb_q) begin
          out1_stb_d = 1'b0;
          state_d    = StGetA;
        end
      end
      default: begin
        state_d = StGetA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StGetA;
      in1_ack_q  <= 1'b0;
      in2_ack_q  <= 1'b0;
      out1_stb_q <= 1'b0;
      out1_q     <= '0;
      quo_q      <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      a_neg_q    <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in1_ack_q  <= in1_ack_d;
      in2_ack_q  <= in2_ack_d;
      out1_stb_q <= out1_stb_d;
      out1_q     <= out1_d;
      quo_q      <= quo_d;
      den_q      <= den_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      a_neg_q    <= a_neg_d;
      neg_q      <= neg_d;
    end
  end

  assign in1_ack  = in1_ack_q;
  assign in2_ack  = in2_ack_q;
  assign out1     = out1_q;
  assign out1_stb = out1_stb_q;

endmodule

// File: tb/tb_divider.sv
module tb_divider;

  localparam int W = 16;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in1, in2;
  logic         in1_stb, in2_stb;
  logic         in1_ack, in2_ack;
  logic [W-1:0] out1;
  logic         out1_stb;
  logic         out1_ack;

  int checks = 0;
  int errors = 0;

  divider #(.bits(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in1      (in1),
    .in1_stb  (in1_stb),
    .in1_ack  (in1_ack),
    .in2      (in2),
    .in2_stb  (in2_stb),
    .in2_ack  (in2_ack),
    .out1     (out1),
    .out1_stb (out1_stb),
    .out1_ack (out1_ack)
  );

  always #5 clk = ~clk;

  // Reference: plain signed arithmetic, truncating toward zero, wrapped to W bits.
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return '0;
    return W'(sa / sb);
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0001;
      4: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name,
               $signed(act), act, $signed(req), req);
    end
  endtask

  // Acks must never overlap.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (in1_ack && in2_ack) begin
        errors++;
        $display("FAIL ack_overlap: in1_ack=%b in2_ack=%b expected not both high",
                 in1_ack, in2_ack);
      end
    end
  end

  // One transaction. abort_at > 0 pulses reset that many cycles into DIVIDE
  // and checks that no result appears.
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp,
                        input int d1, input int d2, input int ack_delay, input int abort_at,
                        input string name);
    logic in1_done;
    in1_done = 1'b0;
    out1_ack = (ack_delay == 0);
    fork
      begin : drv1
        bit ok;
        repeat (d1 + 1) @(posedge clk);
        #1 in1 = a; in1_stb = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (in1_ack) begin ok = 1'b1; break; end
        end
        if (!ok) begin
          errors++;
          $display("FAIL %s in1_timeout: in1_ack low for 200 cycles, expected high", name);
        end
        @(posedge clk);
        in1_done = 1'b1;
        #1 in1_stb = 1'b0; in1 = W'($urandom);
      end
      begin : drv2
        bit ok;
        int n;
        logic [W-1:0] v;
        repeat (d2 + 1) @(posedge clk);
        #1 in2 = b; in2_stb = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 250; i++) begin
          @(negedge clk);
          if (in2_ack) begin ok = 1'b1; break; end
        end
        if (!ok) begin
          errors++;
          $display("FAIL %s in2_timeout: in2_ack low for 250 cycles, expected high", name);
        end
        chk({name, " in2_after_in1"}, {15'd0, in1_done}, 16'd1);
        @(posedge clk);
        #1 in2_stb = 1'b0; in2 = W'($urandom);
        if (abort_at > 0) begin
          repeat (abort_at - 1) @(posedge clk);
          #1 rst = 1'b1;
          @(posedge clk);
          #1 rst = 1'b0;
          @(negedge clk);
          chk({name, " ack_low_before_edge"}, {15'd0, in1_ack}, 16'd0);
          @(negedge clk);
          chk({name, " ack_rises_after_rst"}, {15'd0, in1_ack}, 16'd1);
          for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk({name, " no_stb_after_abort"}, {15'd0, out1_stb}, 16'd0);
          end
        end else begin
          n = 0;
          for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out1_stb) break;
          end
          chk({name, " latency"}, W'(n), W'(LAT));
          v = out1;
          chk({name, " result"}, v, exp);
          for (int k = 0; k < ack_delay; k++) begin
            @(negedge clk);
            chk({name, " hold_data"}, out1, v);
            chk({name, " hold_stb"}, {15'd0, out1_stb}, 16'd1);
            chk({name, " in1_ack_low"}, {15'd0, in1_ack}, 16'd0);
          end
          if (ack_delay > 0) begin
            @(posedge clk);
            #1 out1_ack = 1'b1;
          end
          @(posedge clk);
          #1 out1_ack = 1'b0;
          @(negedge clk);
          chk({name, " stb_drops"}, {15'd0, out1_stb}, 16'd0);
        end
      end
    join
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           ack_delay;
    string        name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    rst = 1'b1;
    in1 = '0; in2 = '0; in1_stb = 1'b0; in2_stb = 1'b0; out1_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst in1_ack", {15'd0, in1_ack}, 16'd0);
    chk("rst in2_ack", {15'd0, in2_ack}, 16'd0);
    chk("rst out1_stb", {15'd0, out1_stb}, 16'd0);
    chk("rst out1", out1, 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst ack_waits", {15'd0, in1_ack}, 16'd0);
    @(negedge clk);
    chk("rst ack_rises", {15'd0, in1_ack}, 16'd1);

    vecs.push_back('{16'd100, 16'd7, 16'd14, 0, "basic"});
    vecs.push_back('{-16'sd100, 16'd7, -16'sd14, 0, "neg_pos"});
    vecs.push_back('{16'd100, -16'sd7, -16'sd14, 0, "pos_neg"});
    vecs.push_back('{-16'sd100, -16'sd7, 16'd14, 0, "neg_neg"});
    vecs.push_back('{-16'sd7, 16'd2, -16'sd3, 0, "trunc_a"});
    vecs.push_back('{16'd7, -16'sd2, -16'sd3, 0, "trunc_b"});
    vecs.push_back('{16'd5, 16'd0, 16'd0, 0, "div_zero"});
    vecs.push_back('{16'h8000, 16'hFFFF, 16'h8000, 0, "overflow"});
    vecs.push_back('{16'h8000, 16'd1, 16'h8000, 0, "min_by_one"});
    vecs.push_back('{16'd0, 16'd5, 16'd0, 0, "zero_num"});
    vecs.push_back('{16'd32767, 16'd32767, 16'd1, 0, "max_max"});
    vecs.push_back('{16'd1000, 16'd3, 16'd333, 50, "backpressure"});

    foreach (vecs[i]) begin
      do_txn(vecs[i].a, vecs[i].b, vecs[i].exp, 0, 0, vecs[i].ack_delay, 0, vecs[i].name);
    end

    // Divisor offered well before the dividend.
    do_txn(16'd200, 16'd9, 16'd22, 6, 0, 2, 0, "in2_first");

    // Reset partway through the division, then a clean pair.
    do_txn(16'd1234, 16'd5, 16'd0, 0, 0, 0, 8, "abort");
    do_txn(16'd9, 16'd3, 16'd3, 0, 0, 0, 0, "after_abort");

    for (int i = 0; i < 1500; i++) begin
      a = rand_op();
      b = rand_op();
      do_txn(a, b, ref_div(a, b), $urandom_range(0, 4), $urandom_range(0, 4),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
